// File: rtl/pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : pipe_hazard_ctrl
// Description : Central interlock controller for the 5-stage F/D/A/C/W
//               pipeline. Detects load-use hazards the A-stage bypass cannot
//               cover, merges icache/dcache misses into one freeze, and
//               sequences front-end flushes after an A-stage redirect.
//               All control outputs are combinational from inputs + state.
// Revision    : 1.0 - initial release
//
// Parameters  : FLUSH_CYCLES - extra cycles fd_flush stays high after a
//                              redirect (0..7)
//               CNT_W        - performance counter width
// Optional    : define PIPE_HAZARD_PERF_EN to build the saturating perf
//               counters; otherwise the perf outputs are tied to 0.
//
// Ports       : clock, reset (async, active-low)
//               fd_read_sel1/2, fd_uses_rs1/2   - source operands in F/D
//               da_write_sel, da_is_load, da_is_wb - destination in D/A
//               a_redirect                       - taken branch/jump in A
//               icache_stall, dcache_stall       - cache misses
//               global_stall, pc_hold, fd_hold, da_bubble,
//               fd_flush, da_flush               - stage register controls
//               perf_stall_cycles, perf_bubbles, perf_flushes - counters
//------------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       fd_read_sel1,
  input  logic [4:0]       fd_read_sel2,
  input  logic             fd_uses_rs1,
  input  logic             fd_uses_rs2,
  input  logic [4:0]       da_write_sel,
  input  logic             da_is_load,
  input  logic             da_is_wb,
  input  logic             a_redirect,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             global_stall,
  output logic             pc_hold,
  output logic             fd_hold,
  output logic             da_bubble,
  output logic             fd_flush,
  output logic             da_flush,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_bubbles,
  output logic [CNT_W-1:0] perf_flushes
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [2:0] flush_cnt;
  logic [2:0] flush_cnt_nxt;
  logic       hz;
  logic       cache_stall;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hz = da_is_load & da_is_wb & (da_write_sel != 5'd0) &
              ((fd_uses_rs1 & (fd_read_sel1 == da_write_sel)) |
               (fd_uses_rs2 & (fd_read_sel2 == da_write_sel)));

  assign cache_stall = icache_stall | dcache_stall;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next-state logic. A cache stall freezes everything, so the pending
  // redirect or hazard is simply re-evaluated once the stall clears.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (!cache_stall) begin
      if (a_redirect) begin
        flush_cnt_nxt = FLUSH_INIT;
        state_nxt     = (FLUSH_INIT == 3'd0) ? ST_RUN : ST_FLUSH;
      end else begin
        case (state)
          ST_RUN: begin
            if (hz) state_nxt = ST_LU_STALL;
          end
          ST_LU_STALL: begin
            state_nxt = ST_RUN;
          end
          ST_FLUSH: begin
            flush_cnt_nxt = flush_cnt - 3'd1;
            if (flush_cnt <= 3'd1) state_nxt = ST_RUN;
          end
          default: begin
            state_nxt = ST_RUN;
          end
        endcase
      end
    end
  end

  // Output logic. Gated by reset so every control drops the instant reset
  // is asserted, without waiting for a clock edge.
  always_comb begin
    global_stall = 1'b0;
    pc_hold      = 1'b0;
    fd_hold      = 1'b0;
    da_bubble    = 1'b0;
    fd_flush     = 1'b0;
    da_flush     = 1'b0;
    if (reset) begin
      if (cache_stall) begin
        global_stall = 1'b1;
      end else if (a_redirect) begin
        fd_flush = 1'b1;
        da_flush = 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            if (hz) begin
              pc_hold   = 1'b1;
              fd_hold   = 1'b1;
              da_bubble = 1'b1;
            end
          end
          ST_FLUSH: begin
            fd_flush = 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_bubble;
  logic [CNT_W-1:0] cnt_flush;
  logic             bubble_evt;
  logic             flush_evt;

  assign bubble_evt = ~cache_stall & ~a_redirect & (state == ST_RUN) & hz;
  assign flush_evt  = ~cache_stall & a_redirect;

  // Saturating counters: stop at all-ones rather than wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_stall  <= '0;
      cnt_bubble <= '0;
      cnt_flush  <= '0;
    end else begin
      if (cache_stall && (cnt_stall != '1)) cnt_stall  <= cnt_stall + 1'b1;
      if (bubble_evt  && (cnt_bubble != '1)) cnt_bubble <= cnt_bubble + 1'b1;
      if (flush_evt   && (cnt_flush != '1)) cnt_flush  <= cnt_flush + 1'b1;
    end
  end

  assign perf_stall_cycles = cnt_stall;
  assign perf_bubbles      = cnt_bubble;
  assign perf_flushes      = cnt_flush;
`else
  assign perf_stall_cycles = '0;
  assign perf_bubbles      = '0;
  assign perf_flushes      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=2).
//               Table vectors from the RUN state, directed multi-cycle
//               sequences, and random stimulus against a reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int FC    = 2;
  localparam int CNT_W = 32;
`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clock;
  logic             reset;
  logic [4:0]       fd_read_sel1;
  logic [4:0]       fd_read_sel2;
  logic             fd_uses_rs1;
  logic             fd_uses_rs2;
  logic [4:0]       da_write_sel;
  logic             da_is_load;
  logic             da_is_wb;
  logic             a_redirect;
  logic             icache_stall;
  logic             dcache_stall;
  logic             global_stall;
  logic             pc_hold;
  logic             fd_hold;
  logic             da_bubble;
  logic             fd_flush;
  logic             da_flush;
  logic [CNT_W-1:0] perf_stall_cycles;
  logic [CNT_W-1:0] perf_bubbles;
  logic [CNT_W-1:0] perf_flushes;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .fd_read_sel1      (fd_read_sel1),
    .fd_read_sel2      (fd_read_sel2),
    .fd_uses_rs1       (fd_uses_rs1),
    .fd_uses_rs2       (fd_uses_rs2),
    .da_write_sel      (da_write_sel),
    .da_is_load        (da_is_load),
    .da_is_wb          (da_is_wb),
    .a_redirect        (a_redirect),
    .icache_stall      (icache_stall),
    .dcache_stall      (dcache_stall),
    .global_stall      (global_stall),
    .pc_hold           (pc_hold),
    .fd_hold           (fd_hold),
    .da_bubble         (da_bubble),
    .fd_flush          (fd_flush),
    .da_flush          (da_flush),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_bubbles      (perf_bubbles),
    .perf_flushes      (perf_flushes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output order: {global_stall, pc_hold, fd_hold, da_bubble, fd_flush, da_flush}
  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] wsel;
    logic       ld;
    logic       wb;
    logic       redir;
    logic       ic;
    logic       dc;
    logic [5:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  function automatic logic [5:0] dut_outs();
    return {global_stall, pc_hold, fd_hold, da_bubble, fd_flush, da_flush};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] wsel, input logic ld, input logic wb,
                        input logic redir, input logic ic, input logic dc);
    fd_read_sel1 = rs1;  fd_read_sel2 = rs2;
    fd_uses_rs1  = u1;   fd_uses_rs2  = u2;
    da_write_sel = wsel; da_is_load   = ld;  da_is_wb = wb;
    a_redirect   = redir; icache_stall = ic; dcache_stall = dc;
  endtask

  task automatic clear_in();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called at posedge+1; leaves the DUT in RUN at posedge+1.
  task automatic do_reset();
    reset = 1'b0;
    clear_in();
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  // Inputs are already applied; sample on the falling edge, advance a cycle.
  task automatic cyc(input string name, input logic [5:0] exp);
    @(negedge clock);
    check(name, {26'd0, dut_outs()}, {26'd0, exp});
    @(posedge clock); #1;
  endtask

  // Hazard condition written straight from the instruction semantics.
  function automatic bit model_hz();
    bit loads_real_reg;
    bit rs1_dep;
    bit rs2_dep;
    loads_real_reg = da_is_load && da_is_wb && (da_write_sel != 5'd0);
    rs1_dep = fd_uses_rs1 && (fd_read_sel1 == da_write_sel);
    rs2_dep = fd_uses_rs2 && (fd_read_sel2 == da_write_sel);
    return loads_real_reg && (rs1_dep || rs2_dep);
  endfunction

  vec_t tbl[11];

  initial begin
    int  flush_left;
    bit  after_bubble;
    int  m_stall, m_bub, m_fl;
    logic [5:0] exp;

    tbl[0]  = '{"lu_rs1",      5'd5, 5'd7, 1, 1, 5'd5, 1, 1, 0, 0, 0, 6'b011100};
    tbl[1]  = '{"x0_dest",     5'd0, 5'd7, 1, 1, 5'd0, 1, 1, 0, 0, 0, 6'b000000};
    tbl[2]  = '{"rs2_unused",  5'd1, 5'd5, 1, 0, 5'd5, 1, 1, 0, 0, 0, 6'b000000};
    tbl[3]  = '{"lu_rs2",      5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0, 6'b011100};
    tbl[4]  = '{"not_load",    5'd5, 5'd7, 1, 1, 5'd5, 0, 1, 0, 0, 0, 6'b000000};
    tbl[5]  = '{"no_wb",       5'd5, 5'd7, 1, 1, 5'd5, 1, 0, 0, 0, 0, 6'b000000};
    tbl[6]  = '{"redir_hz",    5'd5, 5'd7, 1, 1, 5'd5, 1, 1, 1, 0, 0, 6'b000011};
    tbl[7]  = '{"dc_hz",       5'd5, 5'd7, 1, 1, 5'd5, 1, 1, 0, 0, 1, 6'b100000};
    tbl[8]  = '{"ic_redir",    5'd5, 5'd7, 1, 1, 5'd5, 1, 1, 1, 1, 0, 6'b100000};
    tbl[9]  = '{"no_match",    5'd3, 5'd4, 1, 1, 5'd5, 1, 1, 0, 0, 0, 6'b000000};
    tbl[10] = '{"both_match",  5'd9, 5'd9, 1, 1, 5'd9, 1, 1, 0, 0, 0, 6'b011100};

    // Reset state: outputs held low even with active inputs.
    reset = 1'b0;
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    check("reset_outs", {26'd0, dut_outs()}, 32'd0);
    check("reset_perf", perf_stall_cycles | perf_bubbles | perf_flushes, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Table vectors, each from a fresh RUN state.
    foreach (tbl[i]) begin
      do_reset();
      set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].wsel,
             tbl[i].ld, tbl[i].wb, tbl[i].redir, tbl[i].ic, tbl[i].dc);
      cyc(tbl[i].name, tbl[i].exp);
    end

    // Load-use: one bubble cycle, then nothing while the hazard lingers.
    do_reset();
    set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_c0", 6'b011100);
    cyc("lu_c1", 6'b000000);
    clear_in();
    cyc("lu_c2", 6'b000000);
    check("lu_perf_bub", perf_bubbles, PERF ? 32'd1 : 32'd0);

    // Redirect overrides hazard, then FC extra fd_flush cycles.
    do_reset();
    set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("rd_c0", 6'b000011);
    clear_in();
    cyc("rd_c1", 6'b000010);
    cyc("rd_c2", 6'b000010);
    cyc("rd_c3", 6'b000000);
    check("rd_perf_fl", perf_flushes, PERF ? 32'd1 : 32'd0);

    // dcache stall freezes the hazard for 4 cycles; bubble follows.
    do_reset();
    set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cyc($sformatf("dc_c%0d", k), 6'b100000);
    dcache_stall = 1'b0;
    cyc("dc_bubble", 6'b011100);
    check("dc_perf_st", perf_stall_cycles, PERF ? 32'd4 : 32'd0);

    // Redirect under icache stall: flush only once the stall falls.
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("ic_c0", 6'b100000);
    cyc("ic_c1", 6'b100000);
    icache_stall = 1'b0;
    cyc("ic_flush", 6'b000011);
    a_redirect = 1'b0;
    cyc("ic_tail", 6'b000010);

    // Reset in FLUSH with flush_cnt=2: outputs drop immediately.
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("rst_redir", 6'b000011);
    set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    check("rst_pre", {26'd0, dut_outs()}, 32'd3);
    reset = 1'b0;
    #1;
    check("rst_async", {26'd0, dut_outs()}, 32'd0);
    clear_in();
    @(posedge clock); #1;
    reset = 1'b1;
    check("rst_perf", perf_stall_cycles | perf_bubbles | perf_flushes, 32'd0);
    set_in(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("rst_run", 6'b011100);

    // Random stimulus against the reference model.
    do_reset();
    flush_left = 0; after_bubble = 1'b0;
    m_stall = 0; m_bub = 0; m_fl = 0;
    for (int n = 0; n < 2000; n++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
      exp = 6'b0;
      if (icache_stall || dcache_stall) begin
        exp[5] = 1'b1;
        m_stall++;
      end else if (a_redirect) begin
        exp[1:0] = 2'b11;
        m_fl++;
        flush_left = FC;
        after_bubble = 1'b0;
      end else if (flush_left > 0) begin
        exp[1] = 1'b1;
        flush_left--;
      end else if (after_bubble) begin
        after_bubble = 1'b0;
      end else if (model_hz()) begin
        exp[4:2] = 3'b111;
        m_bub++;
        after_bubble = 1'b1;
      end
      cyc($sformatf("rand_%0d", n), exp);
    end
    check("rand_perf_st",  perf_stall_cycles, PERF ? 32'(m_stall) : 32'd0);
    check("rand_perf_bub", perf_bubbles,      PERF ? 32'(m_bub)   : 32'd0);
    check("rand_perf_fl",  perf_flushes,      PERF ? 32'(m_fl)    : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central interlock controller for the 5-stage pipeline (F/D/A/C/W). It detects load-use hazards that the A-stage bypass network cannot cover and inserts a bubble into the D/A register. It merges the icache and dcache stalls into one freeze, and sequences front-end flushes after an A-stage redirect. It sits beside the stage registers and drives their hold, bubble and flush enables combinationally each cycle.

Parameters:
FLUSH_CYCLES, 1, number of extra cycles fd_flush stays asserted after a redirect (covers icache refetch latency); legal range 0..7.
CNT_W, 32, width of the performance counters (only used with the optional feature).

Ports:
clock  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-low reset.
fd_read_sel1  in  5  rs1 index of the instruction in F/D.
fd_read_sel2  in  5  rs2 index of the instruction in F/D.
fd_uses_rs1  in  1  F/D instruction reads rs1.
fd_uses_rs2  in  1  F/D instruction reads rs2 (register form, not immediate).
da_write_sel  in  5  destination register of the instruction in D/A.
da_is_load  in  1  D/A instruction is a load.
da_is_wb  in  1  D/A instruction writes back.
a_redirect  in  1  A stage resolved a taken branch/jump this cycle.
icache_stall  in  1  instruction cache miss in progress.
dcache_stall  in  1  data cache miss in progress.
global_stall  out  1  freeze every stage register.
pc_hold  out  1  PC must not advance.
fd_hold  out  1  F/D register keeps its contents.
da_bubble  out  1  D/A loads a NOP (is_wb/is_load/is_store = 0).
fd_flush  out  1  F/D loads a NOP.
da_flush  out  1  D/A loads a NOP.
perf_stall_cycles  out  CNT_W  cycles with global_stall=1.
perf_bubbles  out  CNT_W  load-use bubbles inserted.
perf_flushes  out  CNT_W  redirects accepted.

Behaviour:
- States: RUN, LU_STALL, FLUSH. Flush down-counter flush_cnt is 3 bits wide.
- reset=0: state=RUN, flush_cnt=0, counters=0. While reset=0, all outputs are forced to 0.
- Hazard: hz = da_is_load & da_is_wb & (da_write_sel!=0) & ((fd_uses_rs1 & fd_read_sel1==da_write_sel) | (fd_uses_rs2 & fd_read_sel2==da_write_sel)).
- Priority, evaluated combinationally each cycle:
  - 1. Cache stall: global_stall = icache_stall|dcache_stall. While it is 1, every other output is 0, and state, flush_cnt and the bubble/flush counters hold. A redirect or hazard is re-evaluated once the stall clears, because the stage registers are frozen.
  - 2. Redirect: a_redirect=1 asserts fd_flush=1 and da_flush=1. pc_hold=0 so the PC takes the target. Next state is FLUSH with flush_cnt=FLUSH_CYCLES; if FLUSH_CYCLES=0, next state is RUN. A redirect overrides hz in the same cycle, and no bubble is inserted.
  - 3. Load-use in RUN: hz=1 asserts pc_hold=fd_hold=da_bubble=1 for exactly one cycle, then next state is LU_STALL.
- LU_STALL: hz is ignored, because D/A already holds the bubble. All outputs are 0 and the state returns to RUN. One bubble is sufficient because the load result then comes from the C/W bypass.
- FLUSH: fd_flush=1, da_flush=0, flush_cnt decrements. When flush_cnt reaches 1, the state returns to RUN. A new a_redirect in FLUSH reloads flush_cnt=FLUSH_CYCLES and asserts da_flush as well.
- hz with da_write_sel=0 never stalls.
- Latency: all control outputs are combinational from inputs plus state, with zero-cycle latency. The state updates on the rising clock edge only.

Optional Feature:
Macro PIPE_HAZARD_PERF_EN.
- Defined: the three perf counters increment on rising edges, saturate at all-ones, and clear on reset.
  - perf_stall_cycles counts cycles with global_stall=1.
  - perf_bubbles counts cycles with da_bubble=1.
  - perf_flushes counts accepted redirects, i.e. a_redirect=1 while global_stall=0.
- Undefined: the counters are not instantiated and the perf outputs are tied to 0.

Test Plan:
- Load-use hazard: D/A holds lw x5 (da_is_load=1, da_is_wb=1, da_write_sel=5) and F/D holds add x6,x5,x7 (fd_uses_rs1=1, fd_read_sel1=5) -> exactly one cycle of pc_hold=fd_hold=da_bubble=1, then all 0. perf_bubbles=1.
- Non-hazard cases: same as above but da_write_sel=0, or fd_uses_rs2=0 with only rs2 matching -> no stall outputs for the whole sequence.
- Redirect overrides hazard: a_redirect=1 in the same cycle as the hazard -> fd_flush=da_flush=1 and da_bubble=0. With FLUSH_CYCLES=2, fd_flush stays 1 for 2 more cycles, then state is RUN. perf_flushes=1.
- Cache stall freezes the hazard: dcache_stall=1 for 4 cycles while the hazard is present -> global_stall=1 and all other outputs 0 for those 4 cycles. The bubble is issued in the cycle after the stall drops. perf_stall_cycles=4.
- Redirect under icache stall: icache_stall=1 with a_redirect=1 -> no flush during the stall. The flush is asserted in the first cycle after icache_stall falls while a_redirect is still 1.
- Reset mid-operation: assert reset=0 while in FLUSH with flush_cnt=2 -> all outputs go to 0 immediately without waiting for a clock edge. After release, state=RUN and the perf counters read 0.
